// File: rtl/coord_bcd_formatter_pkg.sv
//------------------------------------------------------------------------------
// coord_bcd_formatter_pkg : shared constants, FSM states and BCD digit helper
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

package coord_bcd_formatter_pkg;

   localparam int DIGITS = 4;
   localparam int BCD_W  = 4 * DIGITS;
   localparam int DISP_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_CONV_X = 2'd1,
      ST_CONV_Y = 2'd2,
      ST_UPDATE = 2'd3
   } state_t;

   // Double-dabble correction: every digit >= 5 gets +3 before the next shift
   function automatic logic [BCD_W-1:0] bcd_add3(input logic [BCD_W-1:0] b);
      logic [BCD_W-1:0] r;
      r = b;
      for (int i = 0; i < DIGITS; i++) begin
         if (r[4*i +: 4] >= 4'd5) begin
            r[4*i +: 4] = r[4*i +: 4] + 4'd3;
         end
      end
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/coord_bcd_formatter_bin2bcd_seq.sv
//------------------------------------------------------------------------------
// bin2bcd_seq : serial double-dabble converter, W cycles per value, MSB first
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bin2bcd_seq
   import coord_bcd_formatter_pkg::*;
#(
   parameter int W = 10
) (
   input  logic             iCLK,
   input  logic             iRST_N,
   input  logic             start_i,
   input  logic [W-1:0]     value_i,
   output logic [BCD_W-1:0] bcd_o,
   output logic             done_o
);

   localparam int CW = $clog2(W + 1);

   logic [W-1:0]     sh_q;
   logic [BCD_W-1:0] bcd_q;
   logic [CW-1:0]    cnt_q;
   logic             done_q;
   logic [BCD_W-1:0] w_adj;

   assign w_adj = bcd_add3(bcd_q);

   // The start edge already shifts in the MSB (add-3 on a zero accumulator is
   // a no-op), so a value takes exactly W edges including the start edge.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         sh_q   <= '0;
         bcd_q  <= '0;
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else if (start_i) begin
         sh_q   <= value_i << 1;
         bcd_q  <= BCD_W'(value_i[W-1]);
         cnt_q  <= CW'(W - 1);
         done_q <= (W == 1);
      end else if (cnt_q != '0) begin
         sh_q   <= sh_q << 1;
         bcd_q  <= {w_adj[BCD_W-2:0], sh_q[W-1]};
         cnt_q  <= cnt_q - CW'(1);
         done_q <= (cnt_q == CW'(1));
      end else begin
         done_q <= 1'b0;
      end
   end

   assign bcd_o  = bcd_q;
   assign done_o = done_q;

endmodule

`default_nettype wire

// File: rtl/coord_bcd_formatter.sv
//------------------------------------------------------------------------------
// coord_bcd_formatter : converts X/Y spot coordinates to BCD display words
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module coord_bcd_formatter
   import coord_bcd_formatter_pkg::*;
#(
   parameter int W = 10
) (
   input  logic              iCLK,
   input  logic              iRST_N,
   input  logic [W-1:0]      iX,
   input  logic [W-1:0]      iY,
   input  logic              iVALID,
   input  logic              iHOLD,
   output logic [DISP_W-1:0] oDISP1,
   output logic [DISP_W-1:0] oDISP2,
   output logic              oBUSY,
   output logic              oDONE
);

   localparam int PAD_W = DISP_W - BCD_W;

   state_t            state_q, state_d;
   logic [W-1:0]      y_q, y_d;
   logic [BCD_W-1:0]  xbcd_q, xbcd_d;
   logic              pend_vld_q, pend_vld_d;
   logic [W-1:0]      pend_x_q, pend_x_d;
   logic [W-1:0]      pend_y_q, pend_y_d;
   logic [DISP_W-1:0] disp1_q, disp1_d;
   logic [DISP_W-1:0] disp2_q, disp2_d;
   logic              done_q, done_d;

   logic              w_strobe;
   logic              w_start;
   logic [W-1:0]      w_start_val;
   logic [BCD_W-1:0]  w_cvt_bcd;
   logic              w_cvt_done;

   assign w_strobe = iVALID & ~iHOLD;

   bin2bcd_seq #(.W(W)) u_cvt (
      .iCLK    (iCLK),
      .iRST_N  (iRST_N),
      .start_i (w_start),
      .value_i (w_start_val),
      .bcd_o   (w_cvt_bcd),
      .done_o  (w_cvt_done)
   );

   always_comb begin
      state_d     = state_q;
      y_d         = y_q;
      xbcd_d      = xbcd_q;
      pend_vld_d  = pend_vld_q;
      pend_x_d    = pend_x_q;
      pend_y_d    = pend_y_q;
      disp1_d     = disp1_q;
      disp2_d     = disp2_q;
      done_d      = 1'b0;
      w_start     = 1'b0;
      w_start_val = iX;

      unique case (state_q)
         ST_IDLE: begin
            if (w_strobe) begin
               w_start = 1'b1;
               y_d     = iY;
               state_d = ST_CONV_X;
            end
         end
         ST_CONV_X: begin
            if (w_strobe) begin
               pend_vld_d = 1'b1;
               pend_x_d   = iX;
               pend_y_d   = iY;
            end
            if (w_cvt_done) begin
               xbcd_d      = w_cvt_bcd;
               w_start     = 1'b1;
               w_start_val = y_q;
               state_d     = ST_CONV_Y;
            end
         end
         ST_CONV_Y: begin
            if (w_strobe) begin
               pend_vld_d = 1'b1;
               pend_x_d   = iX;
               pend_y_d   = iY;
            end
            if (w_cvt_done) begin
               state_d = ST_UPDATE;
            end
         end
         ST_UPDATE: begin
            if (!iHOLD) begin
               disp1_d = {{PAD_W{1'b0}}, xbcd_q};
               disp2_d = {{PAD_W{1'b0}}, w_cvt_bcd};
               done_d  = 1'b1;
            end
            // A strobe in this very cycle is the newest pair and wins
            if (w_strobe || pend_vld_q) begin
               w_start     = 1'b1;
               w_start_val = w_strobe ? iX : pend_x_q;
               y_d         = w_strobe ? iY : pend_y_q;
               pend_vld_d  = 1'b0;
               state_d     = ST_CONV_X;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state_q    <= ST_IDLE;
         y_q        <= '0;
         xbcd_q     <= '0;
         pend_vld_q <= 1'b0;
         pend_x_q   <= '0;
         pend_y_q   <= '0;
         disp1_q    <= '0;
         disp2_q    <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         y_q        <= y_d;
         xbcd_q     <= xbcd_d;
         pend_vld_q <= pend_vld_d;
         pend_x_q   <= pend_x_d;
         pend_y_q   <= pend_y_d;
         disp1_q    <= disp1_d;
         disp2_q    <= disp2_d;
         done_q     <= done_d;
      end
   end

   assign oDISP1 = disp1_q;
   assign oDISP2 = disp2_q;
   assign oBUSY  = (state_q != ST_IDLE);
   assign oDONE  = done_q;

endmodule

`default_nettype wire

// File: tb/tb_coord_bcd_formatter.sv
//------------------------------------------------------------------------------
// tb_coord_bcd_formatter : scoreboard bench with decimal reference model
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_coord_bcd_formatter;

   localparam int W   = 10;
   localparam int LAT = 2 * W + 1;

   logic          clk;
   logic          rst_n;
   logic [W-1:0]  iX;
   logic [W-1:0]  iY;
   logic          iVALID;
   logic          iHOLD;
   logic [31:0]   oDISP1;
   logic [31:0]   oDISP2;
   logic          oBUSY;
   logic          oDONE;

   coord_bcd_formatter #(.W(W)) dut (
      .iCLK   (clk),
      .iRST_N (rst_n),
      .iX     (iX),
      .iY     (iY),
      .iVALID (iVALID),
      .iHOLD  (iHOLD),
      .oDISP1 (oDISP1),
      .oDISP2 (oDISP2),
      .oBUSY  (oBUSY),
      .oDONE  (oDONE)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   typedef struct {
      logic [31:0] d1;
      logic [31:0] d2;
      int          at;
   } exp_t;

   exp_t        q[$];
   int          total = 0;
   int          bad   = 0;
   logic [31:0] last_d1 = '0;
   logic [31:0] last_d2 = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Decimal reference: each nibble is one base-10 digit of the value
   function automatic logic [31:0] ref_bcd(input int v);
      return {16'h0, 4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
   endfunction

   task automatic push_exp(input int x, input int y, input int at);
      exp_t e;
      e.d1 = ref_bcd(x);
      e.d2 = ref_bcd(y);
      e.at = at;
      q.push_back(e);
      last_d1 = e.d1;
      last_d2 = e.d2;
   endtask

   // Called at a negedge; returns at the next negedge with cyc == strobe edge
   task automatic strobe(input int x, input int y, output int n);
      iX     = W'(x);
      iY     = W'(y);
      iVALID = 1'b1;
      n      = cyc + 1;
      @(negedge clk);
      iVALID = 1'b0;
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      while (oBUSY && k < 200) begin
         @(negedge clk);
         k++;
      end
      if (k >= 200) begin
         total++;
         bad++;
         $display("FAIL idle_timeout: oBUSY still 1 after %0d cycles, required 0", k);
      end
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst_n && oDONE) begin
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done: oDONE=1 at cycle %0d, required 0", cyc);
         end else begin
            e = q.pop_front();
            check("disp1", oDISP1, e.d1);
            check("disp2", oDISP2, e.d2);
            check("done_cycle", cyc, e.at);
         end
      end
   end

   initial begin : watchdog
      #2ms;
      $display("FAIL watchdog: simulation exceeded time limit, required completion");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int n;
      int m;
      int cnt;
      int x;
      int y;

      rst_n  = 1'b0;
      iX     = '0;
      iY     = '0;
      iVALID = 1'b0;
      iHOLD  = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_disp1", oDISP1, 32'h0);
      check("rst_disp2", oDISP2, 32'h0);
      check("rst_busy", {31'h0, oBUSY}, 32'h0);
      check("rst_done", {31'h0, oDONE}, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);

      strobe(639, 479, n);
      push_exp(639, 479, n + LAT);
      wait_idle();

      strobe(0, 1023, n);
      push_exp(0, 1023, n + LAT);
      cnt = 0;
      while (oBUSY && cnt < 100) begin
         cnt++;
         @(negedge clk);
      end
      check("busy_cycles", cnt, LAT);

      // Pending overwrite: (5,6) is replaced by (7,8) before the first pair ends
      strobe(100, 200, n);
      push_exp(100, 200, n + LAT);
      repeat (2) @(negedge clk);
      strobe(5, 6, m);
      @(negedge clk);
      strobe(7, 8, m);
      push_exp(7, 8, n + 2 * LAT);
      wait_idle();

      iVALID = 1'b1;
      iHOLD  = 1'b1;
      @(negedge clk);
      iVALID = 1'b0;
      iHOLD  = 1'b0;
      repeat (2) @(negedge clk);
      check("hold_idle_busy", {31'h0, oBUSY}, 32'h0);

      strobe(123, 456, n);
      repeat (20) @(negedge clk);
      iHOLD = 1'b1;
      @(negedge clk);
      iHOLD = 1'b0;
      wait_idle();
      check("hold_upd_disp1", oDISP1, last_d1);
      check("hold_upd_disp2", oDISP2, last_d2);

      strobe(321, 654, n);
      repeat (9) @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_disp1", oDISP1, 32'h0);
      check("midrst_disp2", oDISP2, 32'h0);
      check("midrst_busy", {31'h0, oBUSY}, 32'h0);
      last_d1 = '0;
      last_d2 = '0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      check("postrst_busy", {31'h0, oBUSY}, 32'h0);
      check("postrst_disp1", oDISP1, 32'h0);

      for (int i = 0; i < 1000; i++) begin
         x = int'($urandom_range(0, 1023));
         y = int'($urandom_range(0, 1023));
         strobe(x, y, n);
         push_exp(x, y, n + LAT);
         wait_idle();
      end

      repeat (3) @(negedge clk);
      check("queue_empty", q.size(), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/coord_bcd_formatter.md
COORD_BCD_FORMATTER -- requirements
Module: coord_bcd_formatter

Interface
REQ-001 Parameter W, default 10, binary coordinate width; legal range 1..13 (result always fits 4 BCD digits).
REQ-002 iCLK  input  1  sole clock; all state updates on rising edge.
REQ-003 iRST_N  input  1  reset, asynchronous, active-low.
REQ-004 iX  input  W  unsigned binary X coordinate of laser spot.
REQ-005 iY  input  W  unsigned binary Y coordinate of laser spot.
REQ-006 iVALID  input  1  one-cycle strobe; iX/iY valid in same cycle.
REQ-007 iHOLD  input  1  freeze; high suppresses display updates.
REQ-008 oDISP1  output  32  X as BCD in [15:0] (digit 0 = [3:0]); [31:16] always 0; feeds the 8-digit 7-seg driver's low group.
REQ-009 oDISP2  output  32  Y as BCD, same format; feeds high group.
REQ-010 oBUSY  output  1  high while a conversion is in progress.
REQ-011 oDONE  output  1  one-cycle pulse when oDISP1/oDISP2 are updated.

Function
REQ-012 FSM states: IDLE, CONV_X, CONV_Y, UPDATE.
REQ-013 IDLE: iVALID=1 and iHOLD=0 at edge N -> capture iX/iY, enter CONV_X at edge N.
REQ-014 CONV_X: sequential shift-add-3 (double dabble), one bit per cycle MSB first, exactly W cycles, then CONV_Y.
REQ-015 CONV_Y: same algorithm on captured Y, exactly W cycles, then UPDATE.
REQ-016 UPDATE: one cycle; if iHOLD=0 write both BCD results to oDISP1/oDISP2 and pulse oDONE; if iHOLD=1 discard results, no oDONE.
REQ-017 Latency: with W=10, strobe at edge N -> outputs and oDONE change at edge N+21 (2W+1).
REQ-018 oBUSY high in CONV_X, CONV_Y, UPDATE; low in IDLE.
REQ-019 Add-3 correction applies to every digit >=5 before each shift; 16-bit BCD accumulator, no overflow for W<=13.
REQ-020 oDISP1 and oDISP2 always change together in one edge; never a mixed old/new pair.
REQ-021 One-deep pending buffer: iVALID (iHOLD=0) while oBUSY=1 stores iX/iY in pending regs, overwriting any older pending pair.
REQ-022 On leaving UPDATE with pending valid: clear pending, load pending pair, enter CONV_X directly (no IDLE cycle).
REQ-023 iVALID in UPDATE cycle is treated as pending and restarts per REQ-022.
REQ-024 iVALID while iHOLD=1 is ignored in every state.

Reset
REQ-025 iRST_N low -> immediately: state IDLE, oDISP1=oDISP2=32'h0, oBUSY=0, oDONE=0, pending cleared, accumulators cleared.
REQ-026 Reset mid-conversion abandons it; no oDONE follows; outputs stay 0 until next completed conversion.
REQ-027 First conversion after deassertion requires a fresh iVALID.

Structure
REQ-028 Shared package holds: DIGITS=4 constant, BCD width (16), FSM state enum, display word width (32).
REQ-029 One sub-module bin2bcd_seq (start, W-bit value in, 16-bit BCD out, done), instantiated once and reused for X then Y.
REQ-030 Outputs registered; no combinational path from inputs to outputs.

Verification
REQ-031 iX=639, iY=479 strobe at edge N -> edge N+21: oDISP1=32'h00000639, oDISP2=32'h00000479, oDONE one cycle.
REQ-032 iX=0, iY=1023 -> oDISP1=32'h00000000, oDISP2=32'h00001023; oBUSY high exactly 21 cycles.
REQ-033 Strobe (100,200), then (5,6) at N+3, then (7,8) at N+5 -> (100,200) shown at N+21, then (7,8) at N+42 with no IDLE gap; (5,6) never shown.
REQ-034 iHOLD=1 during UPDATE -> outputs keep prior values, no oDONE; iVALID with iHOLD=1 in IDLE -> oBUSY stays 0.
REQ-035 iRST_N low at N+10 of a conversion -> outputs 0, oBUSY 0 asynchronously; no oDONE after release until a new strobe.
REQ-036 Random iX/iY sweep (W=10, 1000 pairs) vs. reference decimal model: every digit 0..9, [31:16]=0.
